// File: rtl/cv32e40x_xif_aes_commit_ctrl.sv
// cv32e40x_xif_aes_commit_ctrl: tracks accepted AES32 instructions until commit/kill and gates FU results onto XIF.
// Optional flush input enabled by defining CV32E40X_XIF_AES_FLUSH_EN.
module cv32e40x_xif_aes_commit_ctrl #(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef CV32E40X_XIF_AES_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  acc_valid_i,
    output logic                  acc_ready_o,
    input  logic [X_ID_WIDTH-1:0] acc_id_i,
    input  logic [4:0]            acc_rd_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  fu_valid_i,
    output logic                  fu_ready_o,
    input  logic [X_ID_WIDTH-1:0] fu_id_i,
    input  logic [31:0]           fu_data_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic [31:0]           result_data_o,
    output logic                  err_o
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {FREE, PEND, CMT, KILL} state_t;

    state_t                st  [DEPTH];
    logic [X_ID_WIDTH-1:0] ids [DEPTH];
    logic [4:0]            rds [DEPTH];
    logic [PW-1:0]         head, tail;
    logic [PW:0]           count;
    logic [1:0]            head_st;
    logic                  flush, commit_en, bypass, push, id_bad, out_free, release_h, load;

`ifdef CV32E40X_XIF_AES_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Head state as seen this cycle, including a same-cycle commit or flush
    assign commit_en   = commit_valid_i & !flush;
    assign bypass      = commit_en && st[head] == PEND && commit_id_i == ids[head];
    assign head_st     = (flush && st[head] == PEND) ? KILL :
                         bypass ? (commit_kill_i ? KILL : CMT) : st[head];
    assign id_bad      = fu_valid_i && (st[head] == FREE || fu_id_i != ids[head]);
    assign out_free    = !result_valid_o | result_ready_i;
    assign release_h   = fu_valid_i && !id_bad && (head_st == KILL || (head_st == CMT && out_free));
    assign load        = release_h && head_st == CMT;
    assign fu_ready_o  = !rst_i & (id_bad | release_h);
    assign acc_ready_o = !count[PW] & !flush;
    assign push        = acc_valid_i & acc_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
            err_o          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                st[i]  <= FREE;
                ids[i] <= '0;
                rds[i] <= '0;
            end
        end else begin
            err_o <= err_o | (acc_valid_i & count[PW]) | id_bad;
            for (int i = 0; i < DEPTH; i++) begin
                if (release_h && PW'(i) == head)
                    st[i] <= FREE;
                else if (st[i] == PEND && (flush || (commit_en && commit_id_i == ids[i])))
                    st[i] <= flush || commit_kill_i ? KILL : CMT;
                if (push && PW'(i) == tail) begin
                    ids[i] <= acc_id_i;
                    rds[i] <= acc_rd_i;
                    st[i]  <= PEND;
                end
            end
            head  <= head + PW'(release_h);
            tail  <= tail + PW'(push);
            count <= count + (PW+1)'(push) - (PW+1)'(release_h);
            if (load) begin
                result_valid_o <= 1'b1;
                result_id_o    <= ids[head];
                result_rd_o    <= rds[head];
                result_data_o  <= fu_data_i;
            end else if (result_ready_i) begin
                result_valid_o <= 1'b0;
            end
        end
    end
endmodule
